instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Producer side of the instruction path: fetches 32-bit instructions from instruction
//   memory over a req/ack handshake and buffers them in a small prefetch queue.
//   Presents one instruction at a time, with its PC, to the decode/control stage under a
//   valid/ready handshake. A PCSrc redirect from the control stage flushes the queue and
//   restarts fetch at BranchTarget.
// PARAMETERS
//   DEPTH     4             queue entries; power of 2, >= 2
//   RESET_PC  32'h00000000  first fetch address after reset; bits [1:0] must be 0
// PORTS
//   CLK           in   1   clock; all state updates on rising edge
//   nReset        in   1   asynchronous, active-low reset
//   IMemReq       out  1   fetch request; held high until IMemAck
//   IMemAddr      out  32  fetch address; stable while IMemReq high
//   IMemAck       in   1   memory accepts the request; IMemRData is valid in this cycle
//   IMemRData     in   32  fetched instruction word
//   InstrValid    out  1   queue head is valid
//   Instr         out  32  queue-head instruction
//   InstrPC       out  32  address of Instr
//   InstrReady    in   1   decode consumes the head when InstrValid & InstrReady
//   PCSrc         in   1   redirect strobe, one cycle
//   BranchTarget  in   32  redirect address; bits [1:0] ignored (treated as 0)
// BEHAVIOUR
//   - Reset (async, nReset=0): IMemReq=0, IMemAddr=RESET_PC, InstrValid=0, Instr=0,
//     InstrPC=0, queue count=0, FetchPC=RESET_PC, Outstanding=0, Discard=0.
//     The first IMemReq rises on the first edge after nReset deasserts.
//   - Issue: IMemReq may rise only if Outstanding=0 and count+1 <= DEPTH, i.e. the
//     queue has room for the result. At issue, IMemAddr<=FetchPC and Outstanding<=1.
//     At most one request is in flight.
//   - Handshake: once IMemReq is high, it and IMemAddr hold until the cycle IMemAck=1.
//     IMemReq is never withdrawn early, including on redirect. A new request may be
//     issued in the cycle after the ack (back-to-back throughput of 1 per 2 cycles).
//   - Ack with Discard=0: push {IMemAddr, IMemRData} and set FetchPC<=IMemAddr+4
//     (mod 2^32, so 0xFFFFFFFC wraps to 0).
//   - Ack with Discard=1: drop the data, clear Discard, leave FetchPC unchanged.
//   - Output: InstrValid = (count!=0); Instr/InstrPC show the head entry, driven from
//     registered storage and head pointer. Instr/InstrPC are 0 when the queue is empty.
//     Latency is ack cycle N -> InstrValid=1 at cycle N+1.
//   - Pop: on InstrValid & InstrReady, the head pointer advances (mod DEPTH).
//     A push and a pop in the same cycle leave count unchanged. The push is ordered
//     after the pop, so FIFO order is preserved. Overflow is impossible by the issue rule.
//   - Redirect (PCSrc=1 at an edge) has priority over push and pop in that cycle:
//     count<=0 and pointers reset, FetchPC<=BranchTarget&~3.
//     If a request is outstanding and not acked in this cycle, Discard<=1.
//     If it is acked in this cycle, its data is dropped.
//     A further redirect while Discard=1 only updates FetchPC.
//   - InstrReady while InstrValid=0: ignored. PCSrc asserted with an empty queue and
//     Outstanding=0: fetch restarts at the target on the next edge.
// TESTING
//   1. Reset, 1-cycle ack, InstrReady=1, mem[a]=a^32'hA5A5A5A5 -> IMemAddr 0,4,8,...
//      InstrValid one cycle after each ack; Instr/InstrPC match in order.
//   2. InstrReady=0 -> exactly 4 fetches (0x0..0xC), then IMemReq stays 0.
//      Raise InstrReady -> 4 pops on consecutive cycles, then IMemReq resumes at 0x10.
//   3. Queue holding 3 entries, no request in flight, PCSrc=1 with BranchTarget=0x103
//      -> next cycle InstrValid=0; next request IMemAddr=0x100.
//   4. Request to 0x10 in flight, PCSrc=1 with target 0x200, ack 3 cycles later with
//      0xDEADBEEF -> IMemAddr held 0x10 until ack; nothing enqueued;
//      the next request goes to 0x200.
//   5. RESET_PC=0xFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000;
//      InstrPC matches each.
//   6. nReset pulled low mid-handshake (IMemReq=1, 2 entries queued) -> same-cycle
//      IMemReq=0, InstrValid=0, Instr=0; after release, refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the instruction-memory and decode-side handshake signals of the fetch queue.
// master = fetch queue, slave = memory/decode environment.
interface instr_fetch_queue_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRData;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrReady;
    logic        PCSrc;
    logic [31:0] BranchTarget;

    modport master (
        output IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
        input  IMemAck, IMemRData, InstrReady, PCSrc, BranchTarget
    );

    modport slave (
        input  IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
        output IMemAck, IMemRData, InstrReady, PCSrc, BranchTarget
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: one-outstanding req/ack fetch into a small prefetch FIFO,
// drained by decode over valid/ready; a PCSrc redirect flushes and restarts fetch.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  nReset,
    instr_fetch_queue_if.master   bus
);
    // Handshakes: IMemReq/IMemAddr hold until the cycle IMemAck=1 (transfer on that edge);
    // the head entry transfers on any edge where InstrValid & InstrReady.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];

    logic ack;
    logic pop;
    logic push;
    logic valid;

    assign valid = (count_q != '0);
    assign ack   = req_q & bus.IMemAck;
    assign pop   = valid & bus.InstrReady;
    // Redirect wins over push/pop; a discarded response is never enqueued.
    assign push  = ack & ~discard_q & ~bus.PCSrc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (bus.PCSrc) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = bus.BranchTarget & ~32'h3;
            // An un-acked request in flight must have its response thrown away later.
            discard_d  = req_q & ~bus.IMemAck;
        end else begin
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            count_d = count_q - CNT_W'(pop) + CNT_W'(push);
            if (ack) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                end else begin
                    fetch_pc_d = addr_q + 32'd4;
                end
            end
        end

        // Issue only when idle and the response is guaranteed a free slot.
        if (ack) begin
            req_d = 1'b0;
        end else if (!req_q && !bus.PCSrc && (count_q < DEPTH_C)) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_q;
        end
    end

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            discard_q  <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push) begin
                instr_mem_q[tail_q] <= bus.IMemRData;
                pc_mem_q[tail_q]    <= addr_q;
            end
        end
    end

    assign bus.IMemReq    = req_q;
    assign bus.IMemAddr   = addr_q;
    assign bus.InstrValid = valid;
    assign bus.Instr      = valid ? instr_mem_q[head_q] : 32'h0;
    assign bus.InstrPC    = valid ? pc_mem_q[head_q]    : 32'h0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a default-reset instance and a wrap-around
// RESET_PC instance, each answered by a simple instruction-memory responder.
module tb_instr_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic CLK;
    logic n_reset;
    logic n_reset_w;
    logic auto_ack;
    int   errors;
    int   checks;
    logic [31:0] wrap_addr [3];

    instr_fetch_queue_if m_if ();
    instr_fetch_queue_if w_if ();

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .CLK    (CLK),
        .nReset (n_reset),
        .bus    (m_if.master)
    );

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .CLK    (CLK),
        .nReset (n_reset_w),
        .bus    (w_if.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let the memory responders answer any pending request.
    task automatic tick();
        @(posedge CLK);
        #1;
        m_if.IMemAck   = auto_ack && m_if.IMemReq;
        m_if.IMemRData = (auto_ack && m_if.IMemReq) ? (m_if.IMemAddr ^ K) : 32'h0;
        w_if.IMemAck   = w_if.IMemReq;
        w_if.IMemRData = w_if.IMemReq ? (w_if.IMemAddr ^ K) : 32'h0;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        auto_ack = 1'b1;
        n_reset = 1'b0;
        n_reset_w = 1'b0;
        m_if.IMemAck = 1'b0;
        m_if.IMemRData = '0;
        m_if.InstrReady = 1'b1;
        m_if.PCSrc = 1'b0;
        m_if.BranchTarget = '0;
        w_if.IMemAck = 1'b0;
        w_if.IMemRData = '0;
        w_if.InstrReady = 1'b1;
        w_if.PCSrc = 1'b0;
        w_if.BranchTarget = '0;
        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;

        // Reset state and streaming fetch with decode always ready
        tick();
        tick();
        chk("rst_req",   32'(m_if.IMemReq), 32'h0);
        chk("rst_addr",  m_if.IMemAddr, 32'h0);
        chk("rst_valid", 32'(m_if.InstrValid), 32'h0);
        chk("rst_instr", m_if.Instr, 32'h0);
        chk("rst_pc",    m_if.InstrPC, 32'h0);
        n_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_req",    32'(m_if.IMemReq), 32'h1);
            chk("t1_addr",   m_if.IMemAddr, 32'(k * 4));
            chk("t1_gap",    32'(m_if.InstrValid), 32'h0);
            tick();
            chk("t1_valid",  32'(m_if.InstrValid), 32'h1);
            chk("t1_instr",  m_if.Instr, 32'(k * 4) ^ K);
            chk("t1_pc",     m_if.InstrPC, 32'(k * 4));
            chk("t1_reqlow", 32'(m_if.IMemReq), 32'h0);
        end

        // Decode stalled: queue fills with 0x0..0xC then fetch stops
        do_reset();
        m_if.InstrReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_req",    32'(m_if.IMemReq), 32'h1);
            chk("t2_addr",   m_if.IMemAddr, 32'(k * 4));
            tick();
            chk("t2_reqlow", 32'(m_if.IMemReq), 32'h0);
            chk("t2_head",   m_if.InstrPC, 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_full_noreq", 32'(m_if.IMemReq), 32'h0);
        end
        m_if.InstrReady = 1'b1;
        tick();
        chk("t2_pop1_pc",  m_if.InstrPC, 32'h4);
        chk("t2_pop1_req", 32'(m_if.IMemReq), 32'h0);
        tick();
        chk("t2_pop2_pc",  m_if.InstrPC, 32'h8);
        chk("t2_resume_req",  32'(m_if.IMemReq), 32'h1);
        chk("t2_resume_addr", m_if.IMemAddr, 32'h10);
        tick();
        chk("t2_pop3_pc",  m_if.InstrPC, 32'hC);
        tick();
        chk("t2_pop4_pc",    m_if.InstrPC, 32'h10);
        chk("t2_pop4_instr", m_if.Instr, 32'hA5A5A5B5);
        chk("t2_next_addr",  m_if.IMemAddr, 32'h14);

        // Redirect with 3 entries queued and nothing in flight
        do_reset();
        m_if.InstrReady = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("t3_full_valid", 32'(m_if.InstrValid), 32'h1);
        m_if.InstrReady = 1'b1;
        tick();
        chk("t3_idle_req", 32'(m_if.IMemReq), 32'h0);
        chk("t3_head_pc",  m_if.InstrPC, 32'h4);
        m_if.InstrReady = 1'b0;
        m_if.PCSrc = 1'b1;
        m_if.BranchTarget = 32'h0000_0103;
        tick();
        m_if.PCSrc = 1'b0;
        chk("t3_flush_valid", 32'(m_if.InstrValid), 32'h0);
        chk("t3_flush_instr", m_if.Instr, 32'h0);
        chk("t3_flush_pc",    m_if.InstrPC, 32'h0);
        chk("t3_flush_req",   32'(m_if.IMemReq), 32'h0);
        tick();
        chk("t3_tgt_req",  32'(m_if.IMemReq), 32'h1);
        chk("t3_tgt_addr", m_if.IMemAddr, 32'h100);
        tick();
        chk("t3_tgt_pc",    m_if.InstrPC, 32'h100);
        chk("t3_tgt_instr", m_if.Instr, 32'hA5A5A4A5);

        // Redirect while a request is in flight; its late response is discarded
        do_reset();
        m_if.InstrReady = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t4_pre_pc", m_if.InstrPC, 32'hC);
        auto_ack = 1'b0;
        tick();
        chk("t4_req",   32'(m_if.IMemReq), 32'h1);
        chk("t4_addr",  m_if.IMemAddr, 32'h10);
        m_if.PCSrc = 1'b1;
        m_if.BranchTarget = 32'h0000_0200;
        tick();
        m_if.PCSrc = 1'b0;
        chk("t4_hold1_req",  32'(m_if.IMemReq), 32'h1);
        chk("t4_hold1_addr", m_if.IMemAddr, 32'h10);
        tick();
        chk("t4_hold2_addr", m_if.IMemAddr, 32'h10);
        tick();
        chk("t4_hold3_req",  32'(m_if.IMemReq), 32'h1);
        chk("t4_hold3_addr", m_if.IMemAddr, 32'h10);
        chk("t4_hold3_valid", 32'(m_if.InstrValid), 32'h0);
        m_if.IMemAck = 1'b1;
        m_if.IMemRData = 32'hDEADBEEF;
        tick();
        chk("t4_drop_valid", 32'(m_if.InstrValid), 32'h0);
        chk("t4_drop_req",   32'(m_if.IMemReq), 32'h0);
        auto_ack = 1'b1;
        tick();
        chk("t4_tgt_req",  32'(m_if.IMemReq), 32'h1);
        chk("t4_tgt_addr", m_if.IMemAddr, 32'h200);
        tick();
        chk("t4_tgt_pc",    m_if.InstrPC, 32'h200);
        chk("t4_tgt_instr", m_if.Instr, 32'hA5A5A7A5);

        // Address wrap from RESET_PC near the top of the address space
        chk("t5_rst_addr", w_if.IMemAddr, 32'hFFFF_FFF8);
        chk("t5_rst_req",  32'(w_if.IMemReq), 32'h0);
        n_reset_w = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_addr",  w_if.IMemAddr, wrap_addr[k]);
            tick();
            chk("t5_valid", 32'(w_if.InstrValid), 32'h1);
            chk("t5_pc",    w_if.InstrPC, wrap_addr[k]);
            chk("t5_instr", w_if.Instr, wrap_addr[k] ^ K);
        end

        // Asynchronous reset mid-handshake with two entries queued
        do_reset();
        m_if.InstrReady = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        auto_ack = 1'b0;
        tick();
        chk("t6_pre_req",   32'(m_if.IMemReq), 32'h1);
        chk("t6_pre_valid", 32'(m_if.InstrValid), 32'h1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("t6_async_req",   32'(m_if.IMemReq), 32'h0);
        chk("t6_async_valid", 32'(m_if.InstrValid), 32'h0);
        chk("t6_async_instr", m_if.Instr, 32'h0);
        chk("t6_async_addr",  m_if.IMemAddr, 32'h0);
        tick();
        n_reset = 1'b1;
        auto_ack = 1'b1;
        m_if.InstrReady = 1'b1;
        tick();
        chk("t6_refetch_req",  32'(m_if.IMemReq), 32'h1);
        chk("t6_refetch_addr", m_if.IMemAddr, 32'h0);
        tick();
        chk("t6_refetch_pc",    m_if.InstrPC, 32'h0);
        chk("t6_refetch_instr", m_if.Instr, K);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
